// File: rtl/ofm_writeback_controller.sv
// OFM write-back controller for the 1x1 convolution datapath.
// Captures one group of 4 PE results on each rising PE_finish group edge,
// then serialises them to the single-port OFM memory with valid/ready
// backpressure. Addresses are pixel-major: pixel*num_filter + filter.
module ofm_writeback_controller #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cal_start,
    input  logic [10:0]           num_filter,
    input  logic [15:0]           num_pixel,
    input  logic [3:0]            PE_finish,
    input  logic [4*DATA_W-1:0]   PE_data,
    input  logic                  wr_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     addr_ofm,
    output logic [DATA_W-1:0]     data_ofm,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_PE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;

    logic [3:0]              fin_q;
    logic [10:0]             nf_q, nf_d;
    logic [15:0]             np_q, np_d;
    logic [10:0]             fbase_q, fbase_d;
    logic [ADDR_W-1:0]       pbase_q, pbase_d;
    logic [15:0]             pcnt_q, pcnt_d;
    logic [1:0]              lane_q, lane_d;
    logic [3:0][DATA_W-1:0]  obuf_q, obuf_d;

    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    ovf_q, ovf_d;

    logic                    grp_edge;
    logic [1:0]              lane_nx;
    logic [11:0]             fb_lane_nx;
    logic [11:0]             fb_step;

    // A group is only recognised on the cycle all four flags first read high,
    // so a PE_finish held high for several cycles captures once.
    assign grp_edge   = (PE_finish == 4'hF) && (fin_q != 4'hF);
    assign lane_nx    = lane_q + 2'd1;
    // 12-bit sums keep the filter compares from wrapping at 2047+3.
    assign fb_lane_nx = {1'b0, fbase_q} + {10'd0, lane_nx};
    assign fb_step    = {1'b0, fbase_q} + 12'd4;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and next-value logic for counters, buffer and write port.
    always_comb begin
        state_d = state_q;
        nf_d    = nf_q;
        np_d    = np_q;
        fbase_d = fbase_q;
        pbase_d = pbase_q;
        pcnt_d  = pcnt_q;
        lane_d  = lane_q;
        obuf_d  = obuf_q;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                wr_en_d = 1'b0;
                if (cal_start) begin
                    fbase_d = '0;
                    pbase_d = '0;
                    pcnt_d  = '0;
                    lane_d  = '0;
                    ovf_d   = 1'b0;
                    nf_d    = num_filter;
                    np_d    = num_pixel;
                    if ((num_filter == 11'd0) || (num_pixel == 16'd0))
                        state_d = ST_DONE;
                    else
                        state_d = ST_WAIT_PE;
                end
            end

            ST_WAIT_PE: begin
                if (!cal_start) begin
                    state_d = ST_IDLE;
                end else if (grp_edge) begin
                    // Lane 0 is always in range here since fbase < nf, so
                    // the first write goes out the cycle after the edge.
                    obuf_d  = PE_data;
                    lane_d  = 2'd0;
                    wr_en_d = 1'b1;
                    addr_d  = pbase_q + ADDR_W'(fbase_q);
                    data_d  = PE_data[DATA_W-1:0];
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // A second group while draining has nowhere to go: flag it.
                if (grp_edge) ovf_d = 1'b1;
                // Skipped lanes present wr_en=0 and move on without a handshake.
                if (!wr_en_q || wr_ready) begin
                    if (lane_q == 2'd3) begin
                        wr_en_d = 1'b0;
                        if (fb_step >= {1'b0, nf_q}) begin
                            fbase_d = '0;
                            pbase_d = pbase_q + ADDR_W'(nf_q);
                            pcnt_d  = pcnt_q + 16'd1;
                        end else begin
                            fbase_d = fb_step[10:0];
                        end
                        if (pcnt_d == np_q)
                            state_d = ST_DONE;
                        else if (!cal_start)
                            state_d = ST_IDLE;
                        else
                            state_d = ST_WAIT_PE;
                    end else begin
                        lane_d  = lane_nx;
                        wr_en_d = (fb_lane_nx < {1'b0, nf_q});
                        addr_d  = pbase_q + ADDR_W'(fb_lane_nx);
                        data_d  = obuf_q[lane_nx];
                    end
                end
            end

            ST_DONE: begin
                wr_en_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers; reset returns everything to zero immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fin_q   <= '0;
            nf_q    <= '0;
            np_q    <= '0;
            fbase_q <= '0;
            pbase_q <= '0;
            pcnt_q  <= '0;
            lane_q  <= '0;
            obuf_q  <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            fin_q   <= PE_finish;
            nf_q    <= nf_d;
            np_q    <= np_d;
            fbase_q <= fbase_d;
            pbase_q <= pbase_d;
            pcnt_q  <= pcnt_d;
            lane_q  <= lane_d;
            obuf_q  <= obuf_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign addr_ofm = addr_q;
    assign data_ofm = data_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_ofm_writeback_controller.sv
// Scoreboard bench for ofm_writeback_controller. The driver pushes the
// writes each result group should produce (from pixel/filter arithmetic);
// a negedge monitor pops and compares every accepted write.
module tb_ofm_writeback_controller;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cal_start = 1'b0;
    logic [10:0]          num_filter = '0;
    logic [15:0]          num_pixel = '0;
    logic [3:0]           PE_finish = '0;
    logic [4*DATA_W-1:0]  PE_data = '0;
    logic                 wr_ready = 1'b0;
    logic                 wr_en;
    logic [ADDR_W-1:0]    addr_ofm;
    logic [DATA_W-1:0]    data_ofm;
    logic                 busy, done, overflow;

    ofm_writeback_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .cal_start(cal_start),
        .num_filter(num_filter), .num_pixel(num_pixel),
        .PE_finish(PE_finish), .PE_data(PE_data), .wr_ready(wr_ready),
        .wr_en(wr_en), .addr_ofm(addr_ofm), .data_ofm(data_ofm),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0, checks = 0;
    int  wr_total = 0, wen_cyc = 0, done_total = 0;
    bit  rdy_rand = 1'b0;
    int  cur_nf = 0, cur_np = 0, grp_k = 0;

    // monitor-private state
    bit                 stall_v = 1'b0;
    logic [ADDR_W-1:0]  st_a;
    logic [DATA_W-1:0]  st_d;
    wr_t                mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: group k of a layer belongs to pixel k/G, filters 4*(k%G)..+3,
    // with G = ceil(nf/4); filters >= nf are not written.
    task automatic push_group(input logic [3:0][DATA_W-1:0] d, output logic [ADDR_W-1:0] first_a);
        int g, pix, fb;
        wr_t e;
        g   = (cur_nf + 3) / 4;
        pix = grp_k / g;
        fb  = (grp_k % g) * 4;
        first_a = ADDR_W'(pix * cur_nf + fb);
        for (int i = 0; i < 4; i++) begin
            if (fb + i < cur_nf) begin
                e.a = ADDR_W'(pix * cur_nf + fb + i);
                e.d = d[i];
                exp_q.push_back(e);
            end
        end
        grp_k++;
    endtask

    task automatic start_layer(input int nf, input int np);
        cur_nf = nf; cur_np = np; grp_k = 0;
        num_filter = 11'(nf);
        num_pixel  = 16'(np);
        cal_start  = 1'b1;
        step(1);
    endtask

    task automatic send_group(input logic [3:0][DATA_W-1:0] d, input int hold,
                              input bit last, input bit chk_lat);
        logic [ADDR_W-1:0] fa;
        PE_finish = 4'h0;
        step(1);
        PE_finish = 4'hF;
        PE_data   = d;
        push_group(d, fa);
        step(1);
        if (last) cal_start = 1'b0;
        if (chk_lat) begin
            chk("lat_wr_en", 64'(wr_en), 64'd1);
            chk("lat_addr", 64'(addr_ofm), 64'(fa));
            chk("lat_data", 64'(data_ofm), 64'(d[0]));
        end
        if (hold > 1) step(hold - 1);
        PE_finish = 4'h0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d writes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        step(4);
    endtask

    function automatic logic [3:0][DATA_W-1:0] rand_grp();
        logic [3:0][DATA_W-1:0] d;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        return d;
    endfunction

    // random backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rdy_rand) wr_ready = ($urandom_range(0, 3) != 0);
    end

    // monitor: handshake stability, write scoreboard, done counting
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                checks++;
                if (!(wr_en && addr_ofm == st_a && data_ofm == st_d)) begin
                    errors++;
                    $display("FAIL stall_hold: got wen=%0b addr=%0h data=%0h expected wen=1 addr=%0h data=%0h",
                             wr_en, addr_ofm, data_ofm, st_a, st_d);
                end
            end
            if (wr_en) wen_cyc++;
            if (wr_en && wr_ready) begin
                wr_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", addr_ofm, data_ofm);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (addr_ofm !== mon_e.a || data_ofm !== mon_e.d) begin
                        errors++;
                        $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                                 addr_ofm, data_ofm, mon_e.a, mon_e.d);
                    end
                end
            end
            stall_v = wr_en && !wr_ready;
            st_a = addr_ofm;
            st_d = data_ofm;
            if (done) done_total++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, c0, d0, g, tot, nf, np;
        logic [3:0][DATA_W-1:0] d;

        // reset values
        step(2);
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_addr", 64'(addr_ofm), 0);
        chk("rst_data", 64'(data_ofm), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ovf", 64'(overflow), 0);
        reset_n = 1'b1;
        wr_ready = 1'b1;
        step(2);

        // 8 filters x 2 pixels, no backpressure: 16 back-to-back writes
        w0 = wr_total; c0 = wen_cyc; d0 = done_total;
        start_layer(8, 2);
        for (int k = 0; k < 4; k++) begin
            d[0] = 32'h10; d[1] = 32'h11; d[2] = 32'h12; d[3] = 32'h13;
            send_group(d, 1, k == 3, 1'b1);
            wait_drain();
        end
        chk("t1_writes", 64'(wr_total - w0), 16);
        chk("t1_wen_cycles", 64'(wen_cyc - c0), 16);
        chk("t1_done", 64'(done_total - d0), 1);

        // 6 filters: second group writes lanes 0,1 only
        w0 = wr_total; c0 = wen_cyc; d0 = done_total;
        start_layer(6, 1);
        send_group(rand_grp(), 1, 1'b0, 1'b1);
        wait_drain();
        send_group(rand_grp(), 1, 1'b1, 1'b1);
        wait_drain();
        chk("t2_writes", 64'(wr_total - w0), 6);
        chk("t2_wen_cycles", 64'(wen_cyc - c0), 6);
        chk("t2_done", 64'(done_total - d0), 1);

        // 3-cycle stall on lane 1
        w0 = wr_total; d0 = done_total;
        start_layer(4, 1);
        d = rand_grp();
        send_group(d, 1, 1'b1, 1'b1);
        step(1);
        wr_ready = 1'b0;
        step(1);
        chk("stall_wen", 64'(wr_en), 1);
        chk("stall_addr", 64'(addr_ofm), 1);
        chk("stall_data", 64'(data_ofm), 64'(d[1]));
        step(2);
        wr_ready = 1'b1;
        wait_drain();
        chk("t3_writes", 64'(wr_total - w0), 4);
        chk("t3_done", 64'(done_total - d0), 1);

        // held PE_finish, then an edge during drain
        w0 = wr_total; d0 = done_total;
        start_layer(4, 2);
        send_group(rand_grp(), 5, 1'b0, 1'b0);
        wait_drain();
        chk("t4_one_capture", 64'(wr_total - w0), 4);
        chk("t4_no_ovf", 64'(overflow), 0);
        send_group(rand_grp(), 1, 1'b1, 1'b0);
        step(1);
        PE_finish = 4'hF;
        PE_data   = rand_grp();
        step(1);
        PE_finish = 4'h0;
        wait_drain();
        chk("t4_ovf_set", 64'(overflow), 1);
        chk("t4_writes", 64'(wr_total - w0), 8);
        chk("t4_done", 64'(done_total - d0), 1);
        step(3);
        chk("t4_ovf_sticky", 64'(overflow), 1);

        // abort in WAIT_PE after pixel 0
        w0 = wr_total; d0 = done_total;
        start_layer(4, 3);
        chk("t5_ovf_cleared", 64'(overflow), 0);
        send_group(rand_grp(), 1, 1'b0, 1'b0);
        wait_drain();
        cal_start = 1'b0;
        step(5);
        chk("t5_idle", 64'(busy), 0);
        chk("t5_no_done", 64'(done_total - d0), 0);
        chk("t5_writes", 64'(wr_total - w0), 4);

        // reset mid-drain
        start_layer(8, 2);
        send_group(rand_grp(), 1, 1'b0, 1'b0);
        step(1);
        reset_n = 1'b0;
        cal_start = 1'b0;
        #1;
        chk("rst2_wr_en", 64'(wr_en), 0);
        chk("rst2_addr", 64'(addr_ofm), 0);
        chk("rst2_data", 64'(data_ofm), 0);
        chk("rst2_busy", 64'(busy), 0);
        exp_q.delete();
        step(2);
        reset_n = 1'b1;
        step(2);
        chk("rst2_idle", 64'(busy), 0);

        // zero-sized layers: straight to DONE
        for (int z = 0; z < 2; z++) begin
            w0 = wr_total;
            num_filter = (z == 0) ? 11'd4 : 11'd0;
            num_pixel  = (z == 0) ? 16'd0 : 16'd5;
            cal_start  = 1'b1;
            step(1);
            cal_start  = 1'b0;
            chk("zero_done_hi", 64'(done), 1);
            step(1);
            chk("zero_done_lo", 64'(done), 0);
            chk("zero_idle", 64'(busy), 0);
            chk("zero_writes", 64'(wr_total - w0), 0);
        end

        // randomized layers with random backpressure
        rdy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            nf = $urandom_range(1, 13);
            np = $urandom_range(1, 3);
            d0 = done_total;
            start_layer(nf, np);
            g   = (nf + 3) / 4;
            tot = g * np;
            for (int k = 0; k < tot; k++) begin
                send_group(rand_grp(), $urandom_range(1, 3), k == tot - 1, 1'b0);
                wait_drain();
            end
            chk("rand_done", 64'(done_total - d0), 1);
        end
        rdy_rand = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
